// File: rtl/ram_bist_ctrl.sv
// Write/read-back RAM self-test: writes seed^addr to every word, reads it back
// through a one-cycle-latency RAM and counts mismatches.
module ram_bist_ctrl #(
  parameter int unsigned R = 5,
  parameter int unsigned W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2**W-1:0]   seed,
  output logic              wr_rd,
  output logic [R-1:0]      addr,
  output logic [2**W-1:0]   d_in,
  input  logic [2**W-1:0]   d_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [R:0]        err_cnt,
  output logic [R-1:0]      first_err_addr
);

  localparam int unsigned DW    = 2**W;
  localparam int unsigned DEPTH = 2**R;
  localparam logic [R-1:0] LAST_ADDR = R'(DEPTH - 1);
  localparam logic [R:0]   ERR_MAX   = (R+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;

  state_t          state;
  logic [DW-1:0]   seed_reg;
  logic [DW-1:0]   chk_exp;
  logic [R-1:0]    chk_addr;
  logic            chk_valid;
  logic            mismatch_c;
  logic [R:0]      err_next_c;

  // Address is zero-extended or truncated to the data width.
  function automatic logic [DW-1:0] pattern(input logic [R-1:0] a);
    return seed_reg ^ DW'(a);
  endfunction

  // Compare the read data against the expectation captured one cycle earlier.
  assign mismatch_c = chk_valid && (d_out != chk_exp);
  assign err_next_c = (mismatch_c && (err_cnt != ERR_MAX)) ? err_cnt + (R+1)'(1) : err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      seed_reg       <= '0;
      wr_rd          <= 1'b0;
      addr           <= '0;
      d_in           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      chk_exp        <= '0;
      chk_addr       <= '0;
      chk_valid      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            seed_reg       <= seed;
            state          <= WRITE;
            wr_rd          <= 1'b1;
            addr           <= '0;
            d_in           <= seed;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            chk_valid      <= 1'b0;
          end
        end
        WRITE: begin
          if (addr == LAST_ADDR) begin
            state <= READ;
            wr_rd <= 1'b0;
            addr  <= '0;
          end else begin
            addr <= addr + R'(1);
            d_in <= pattern(addr + R'(1));
          end
        end
        READ: begin
          chk_exp   <= pattern(addr);
          chk_addr  <= addr;
          chk_valid <= 1'b1;
          if (mismatch_c) begin
            err_cnt <= err_next_c;
            if (err_cnt == '0) first_err_addr <= chk_addr;
          end
          if (addr == LAST_ADDR) state <= CHECK;
          else                   addr  <= addr + R'(1);
        end
        CHECK: begin
          if (mismatch_c) begin
            err_cnt <= err_next_c;
            if (err_cnt == '0) first_err_addr <= chk_addr;
          end
          chk_valid <= 1'b0;
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          pass      <= (err_next_c == '0);
          wr_rd     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: directed vector table, random fault runs against a
// fault-list model, abort/restart sequences and a small-geometry instance.
module tb_ram_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       wr_rd, busy, done, pass;
  logic [4:0] addr, first_err_addr;
  logic [7:0] d_in, d_out;
  logic [5:0] err_cnt;

  logic       s_start = 1'b0;
  logic [3:0] s_seed = 4'h0;
  logic       s_wr_rd, s_busy, s_done, s_pass;
  logic [2:0] s_addr, s_first;
  logic [3:0] s_d_in, s_d_out;
  logic [3:0] s_err_cnt;

  ram_bist_ctrl #(.R(5), .W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .wr_rd(wr_rd), .addr(addr),
    .d_in(d_in), .d_out(d_out), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  ram_bist_ctrl #(.R(3), .W(2)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .seed(s_seed), .wr_rd(s_wr_rd), .addr(s_addr),
    .d_in(s_d_in), .d_out(s_d_out), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_cnt(s_err_cnt), .first_err_addr(s_first)
  );

  // Synchronous RAM models; flip[] injects read faults per address.
  logic [7:0] mem [32];
  logic [7:0] flip [32];
  logic [3:0] s_mem [8];
  always @(posedge clk) begin
    if (wr_rd) mem[addr] <= d_in;
    d_out <= mem[addr] ^ flip[addr];
    if (s_wr_rd) s_mem[s_addr] <= s_d_in;
    s_d_out <= s_mem[s_addr];
  end

  int checks = 0;
  int errors = 0;
  int wr_cnt, wr_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected result of a run: mismatch count and lowest faulty address.
  function automatic void model(input logic [31:0] m, output int e, output int f);
    e = 0; f = 0;
    for (int a = 31; a >= 0; a--) if (m[a]) begin e++; f = a; end
  endfunction

  typedef struct {
    logic [7:0]  sd;
    logic [31:0] fmask;
    logic [7:0]  fx;
    int          exp_err;
    int          exp_first;
    bit          exp_pass;
    int          restart_at;
  } vec_t;

  vec_t tbl [6];

  task automatic note_write(input logic [7:0] sd);
    if (wr_rd) begin
      if (addr != 5'(wr_cnt) || d_in != (sd ^ {3'b000, addr})) wr_bad++;
      wr_cnt++;
    end
  endtask

  task automatic run_main(input vec_t v);
    int cyc;
    for (int a = 0; a < 32; a++) flip[a] = v.fmask[a] ? v.fx : 8'h00;
    @(negedge clk);
    seed = v.sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_flags", {28'd0, busy, done, pass, wr_rd}, 32'b1001);
    check("start_err_cnt", err_cnt, 0);
    check("start_first", first_err_addr, 0);
    wr_cnt = 0; wr_bad = 0; cyc = 0;
    note_write(v.sd);
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == v.restart_at) begin seed = ~v.sd; start = 1'b1; end
      else start = 1'b0;
      note_write(v.sd);
    end
    start = 1'b0;
    check("run_cycles", cyc, 65);
    check("write_count", wr_cnt, 32);
    check("write_bad", wr_bad, 0);
    check("pass", pass, v.exp_pass);
    check("err_cnt", err_cnt, v.exp_err);
    check("first_err_addr", first_err_addr, v.exp_first);
    check("done_flags", {29'd0, busy, wr_rd, done}, 32'b001);
    check("d_in_hold", d_in, v.sd ^ 8'h1F);
    repeat (3) @(posedge clk);
    #1;
    check("done_stable", {done, pass, err_cnt, first_err_addr}, {1'b1, v.exp_pass, 6'(v.exp_err), 5'(v.exp_first)});
  endtask

  task automatic run_small(input logic [3:0] sd);
    int cyc, cnt, bad;
    @(negedge clk);
    s_seed = sd; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    cyc = 0; cnt = 0; bad = 0;
    while (!s_done && cyc < 100) begin
      if (s_wr_rd) begin
        if (s_addr != 3'(cnt) || s_d_in != (sd ^ {1'b0, s_addr})) bad++;
        cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("small_cycles", cyc, 17);
    check("small_writes", cnt, 8);
    check("small_write_bad", bad, 0);
    check("small_result", {s_pass, s_err_cnt}, {1'b1, 4'd0});
  endtask

  initial begin
    int e, f, k, cyc, done_seen;
    vec_t v;
    for (int a = 0; a < 32; a++) flip[a] = 8'h00;
    tbl[0] = '{8'hA5, 32'h0000_0000, 8'h00, 0, 0, 1'b1, -1};
    tbl[1] = '{8'hA5, 32'h0000_0080, 8'h01, 1, 7, 1'b0, -1};
    tbl[2] = '{8'h3C, 32'h0010_0008, 8'h01, 2, 3, 1'b0, -1};
    tbl[3] = '{8'h00, 32'h0000_0000, 8'h00, 0, 0, 1'b1, -1};
    tbl[4] = '{8'h77, 32'h0000_0000, 8'h00, 0, 0, 1'b1, 10};
    tbl[5] = '{8'hFF, 32'hFFFF_FFFF, 8'h80, 32, 0, 1'b0, -1};

    repeat (2) @(posedge clk);
    #1;
    check("reset_main", {wr_rd, addr, d_in, busy, done, pass, err_cnt, first_err_addr}, 0);
    check("reset_small", {s_wr_rd, s_addr, s_d_in, s_busy, s_done, s_pass, s_err_cnt, s_first}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_main(tbl[i]);

    // Abort a run with reset while READ presents address 10.
    @(negedge clk);
    seed = 8'h5A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(busy && !wr_rd && addr == 5'd10) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reach_read10", cyc, 42);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_reset_outputs", {wr_rd, addr, d_in, busy, done, pass, err_cnt, first_err_addr}, 0);
    done_seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    for (int i = 0; i < 6; i++) begin
      v.sd = 8'($urandom);
      v.fmask = 32'h0;
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) v.fmask[$urandom_range(0, 31)] = 1'b1;
      v.fx = 8'($urandom_range(1, 255));
      model(v.fmask, e, f);
      v.exp_err = e; v.exp_first = f; v.exp_pass = (e == 0); v.restart_at = -1;
      run_main(v);
    end

    run_small(4'h9);
    run_small(4'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 The block SHALL have parameter R, default 5, RAM address width in bits (depth 2**R words).
REQ-002 The block SHALL have parameter W, default 3, log2 of RAM data width (data width 2**W bits).
REQ-003 The block SHALL have port clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, begin a write/read-back test run.
REQ-006 The block SHALL have port seed, input, 2**W bits, test pattern seed, sampled at start.
REQ-007 The block SHALL have port wr_rd, output, 1 bit, RAM command: 1 = write, 0 = read.
REQ-008 The block SHALL have port addr, output, R bits, RAM address.
REQ-009 The block SHALL have port d_in, output, 2**W bits, write data to RAM.
REQ-010 The block SHALL have port d_out, input, 2**W bits, read data from RAM, valid one cycle after a read address is presented.
REQ-011 The block SHALL have port busy, output, 1 bit, run in progress.
REQ-012 The block SHALL have port done, output, 1 bit, run complete and results valid.
REQ-013 The block SHALL have port pass, output, 1 bit, 1 when the completed run had zero mismatches.
REQ-014 The block SHALL have port err_cnt, output, R+1 bits, mismatch count of the current or last run.
REQ-015 The block SHALL have port first_err_addr, output, R bits, address of the first mismatch.

Function
REQ-016 The block SHALL implement the FSM states IDLE, WRITE, READ, CHECK and DONE.
REQ-017 The block SHALL define pattern(a) = seed_reg XOR a, with a zero-extended or truncated to 2**W bits.
REQ-018 In IDLE or DONE, start=1 at an edge SHALL cause: seed latched; state WRITE; wr_rd=1; addr=0; d_in=pattern(0); busy=1; done=0; pass=0; err_cnt=0; first_err_addr=0.
REQ-019 In WRITE, the block SHALL increment addr by 1 each cycle with d_in=pattern(addr), presenting each address for exactly one cycle.
REQ-020 After addr=2**R-1 has been presented in WRITE, the next edge SHALL enter READ with wr_rd=0 and addr=0.
REQ-021 In READ, the block SHALL increment addr each cycle, register the expected value pattern(addr) and the address, and compare d_out against them on the following cycle.
REQ-022 After addr=2**R-1 has been presented in READ, the next edge SHALL enter CHECK, which performs the final comparison.
REQ-023 On a mismatch, the block SHALL increment err_cnt; if err_cnt was 0, first_err_addr SHALL take the compared address.
REQ-024 err_cnt SHALL NOT wrap: its maximum is 2**R, which fits in R+1 bits.
REQ-025 CHECK SHALL last one cycle, then enter DONE with busy=0, done=1, pass=(final err_cnt==0) and wr_rd=0.
REQ-026 DONE SHALL hold done, pass, err_cnt and first_err_addr stable until the next start or rst.
REQ-027 A run SHALL last 2**R write + 2**R read + 1 check = 2**(R+1)+1 cycles from the start edge to the done=1 edge (65 for R=5).
REQ-028 start SHALL be ignored while busy=1.
REQ-029 d_in SHALL hold its last value outside WRITE, and wr_rd SHALL be 0 in every state except WRITE.

Reset
REQ-030 When rst=1 at an edge, the block SHALL enter IDLE with wr_rd=0, addr=0, d_in=0, busy=0, done=0, pass=0, err_cnt=0 and first_err_addr=0.
REQ-031 rst SHALL take priority over start and SHALL abort a run in any state, including mid-WRITE and mid-READ; no done SHALL follow an aborted run.

Verification
REQ-032 With an ideal RAM model, R=5, W=3, and start pulsed with seed=8'hA5, the bench SHALL check writes to addr 0..31 with d_in=A5^addr; done=1 65 cycles after start; pass=1; err_cnt=0.
REQ-033 With the RAM model forcing bit0 of the data read at addr 7 to be inverted, the bench SHALL check err_cnt=1, first_err_addr=7, pass=0.
REQ-034 With faults at addr 3 and addr 20, the bench SHALL check err_cnt=2 and first_err_addr=3.
REQ-035 With start pulsed again mid-WRITE, the bench SHALL check it is ignored; with rst asserted when READ addr=10, the bench SHALL check all outputs at reset values at the next edge and done never asserting.
REQ-036 With start pulsed in DONE using seed=8'h00, the bench SHALL check done=0, err_cnt=0 and busy=1 at the next edge, and a fresh pass result.
REQ-037 With R=3, W=2, the bench SHALL check a run length of 17 cycles and d_in=seed^addr on 4 bits.
